axis_pattern_gen: RTL and testbench

AXI4-Stream video source (transmitter) that produces raster frames for the filter chain (threshold and the other pixel filters). It generates per-pixel data from a selectable test pattern, with tuser = start-of-frame and tlast = end-of-line. It honours full valid/ready backpressure. It is used as the bench stimulus source and as the on-chip source for bring-up on Artix-7.

---
 rtl/axis_vision_pkg.sv | 39 +++
 rtl/axis_pattern_gen.sv | 210 +++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_vision_pkg.sv
// Shared types and the pixel pattern function for the AXI4-Stream video blocks.
package axis_vision_pkg;

    // Working width of the pattern function; DATA_WIDTH and CNT_W must not exceed it.
    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } gen_state_e;

    function automatic logic [PIX_W-1:0] pattern_pixel(
        input pattern_e         pat,
        input logic [PIX_W-1:0] x,
        input logic [PIX_W-1:0] y,
        input logic [PIX_W-1:0] frame_idx,
        input logic [PIX_W-1:0] solid_value,
        input logic [3:0]       check_shift
    );
        logic [PIX_W-1:0] r;
        case (pat)
            PAT_SOLID: r = solid_value;
            PAT_HRAMP: r = x + frame_idx;
            PAT_VRAMP: r = y + frame_idx;
            PAT_CHECK: r = (x[check_shift] ^ y[check_shift]) ? solid_value : '0;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Raster test-pattern source on AXI4-Stream: tuser marks start of frame, tlast end of line.
//
// state | meaning
// IDLE  | no stream; waits for enable with a legal config
// RUN   | presenting beats of the current frame
// GAP   | inter-frame idle, gap counter running down to zero
module axis_pattern_gen
    import axis_vision_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_WIDTH   = 1920,
    parameter int MAX_HEIGHT  = 1080,
    parameter int CHECK_SHIFT = 3,
    parameter int CNT_W       = $clog2(MAX_WIDTH > MAX_HEIGHT ? MAX_WIDTH : MAX_HEIGHT) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] solid_value,
    input  logic [CNT_W-1:0]      frame_width,
    input  logic [CNT_W-1:0]      frame_height,
    input  logic [15:0]           gap_cycles,
    input  logic [15:0]           frames_to_send,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_error
);

    gen_state_e            state, state_n;
    logic [CNT_W-1:0]      x, x_n, y, y_n;
    logic [DATA_WIDTH-1:0] frame_idx, fidx_n;
    logic [15:0]           sent, sent_n, gap_cnt, gap_cnt_n;

    pattern_e              pat_q, pat_n;
    logic [DATA_WIDTH-1:0] solid_q, solid_n;
    logic [CNT_W-1:0]      w_q, w_n, h_q, h_n;
    logic [15:0]           gap_q, gap_n, frames_q, frames_n;

    logic                  tvalid_n, tlast_n, tuser_n, done_n, err_n, busy_n;
    logic [DATA_WIDTH-1:0] tdata_n;
    logic                  cfg_legal, start, accept, last_col, last_row;

    function automatic logic [DATA_WIDTH-1:0] pix(
        input pattern_e              p,
        input logic [CNT_W-1:0]      px,
        input logic [CNT_W-1:0]      py,
        input logic [DATA_WIDTH-1:0] fi,
        input logic [DATA_WIDTH-1:0] sv
    );
        logic [PIX_W-1:0] r;
        r = pattern_pixel(p, PIX_W'(px), PIX_W'(py), PIX_W'(fi), PIX_W'(sv), 4'(CHECK_SHIFT));
        return r[DATA_WIDTH-1:0];
    endfunction

    assign cfg_legal = (frame_width  != '0) && (frame_width  <= CNT_W'(MAX_WIDTH)) &&
                       (frame_height != '0) && (frame_height <= CNT_W'(MAX_HEIGHT));
    assign accept    = m_axis_tvalid && m_axis_tready;
    assign last_col  = (x == w_q - CNT_W'(1));
    assign last_row  = (y == h_q - CNT_W'(1));

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        fidx_n    = frame_idx;
        sent_n    = sent;
        gap_cnt_n = gap_cnt;
        pat_n     = pat_q;
        solid_n   = solid_q;
        w_n       = w_q;
        h_n       = h_q;
        gap_n     = gap_q;
        frames_n  = frames_q;
        tvalid_n  = m_axis_tvalid;
        tdata_n   = m_axis_tdata;
        tlast_n   = m_axis_tlast;
        tuser_n   = m_axis_tuser;
        done_n    = 1'b0;
        err_n     = enable ? cfg_error : 1'b0;
        start     = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    if (cfg_legal) begin
                        start  = 1'b1;
                        sent_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_col && last_row) begin
                        done_n = 1'b1;
                        fidx_n = frame_idx + DATA_WIDTH'(1);
                        sent_n = sent + 16'd1;
                        if (((frames_q != 16'd0) && (sent_n == frames_q)) || !enable) begin
                            state_n = IDLE;
                        end else if (gap_q == 16'd0) begin
                            if (cfg_legal) start = 1'b1;
                            else begin
                                err_n   = 1'b1;
                                state_n = IDLE;
                            end
                        end else begin
                            state_n   = GAP;
                            gap_cnt_n = gap_q - 16'd1;
                        end
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                        tuser_n  = 1'b0;
                    end else begin
                        x_n      = last_col ? '0 : x + CNT_W'(1);
                        y_n      = last_col ? y + CNT_W'(1) : y;
                        tdata_n  = pix(pat_q, x_n, y_n, frame_idx, solid_q);
                        tlast_n  = (x_n == w_q - CNT_W'(1));
                        tuser_n  = 1'b0;
                    end
                end
            end
            GAP: begin
                // Dropping enable during the gap abandons the next frame rather than starting it.
                if (!enable) begin
                    state_n = IDLE;
                end else if (gap_cnt == 16'd0) begin
                    if (cfg_legal) start = 1'b1;
                    else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            pat_n    = pattern_e'(pattern_sel);
            solid_n  = solid_value;
            w_n      = frame_width;
            h_n      = frame_height;
            gap_n    = gap_cycles;
            frames_n = frames_to_send;
            state_n  = RUN;
            x_n      = '0;
            y_n      = '0;
            tvalid_n = 1'b1;
            tuser_n  = 1'b1;
            tlast_n  = (frame_width == CNT_W'(1));
            tdata_n  = pix(pattern_e'(pattern_sel), '0, '0, fidx_n, solid_value);
        end

        if (state_n == IDLE) tdata_n = '0;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            frame_idx     <= '0;
            sent          <= '0;
            gap_cnt       <= '0;
            pat_q         <= PAT_SOLID;
            solid_q       <= '0;
            w_q           <= '0;
            h_q           <= '0;
            gap_q         <= '0;
            frames_q      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            frame_idx     <= fidx_n;
            sent          <= sent_n;
            gap_cnt       <= gap_cnt_n;
            pat_q         <= pat_n;
            solid_q       <= solid_n;
            w_q           <= w_n;
            h_q           <= h_n;
            gap_q         <= gap_n;
            frames_q      <= frames_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tlast  <= tlast_n;
            m_axis_tuser  <= tuser_n;
            busy          <= busy_n;
            frame_done    <= done_n;
            cfg_error     <= err_n;
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: stimulus pushes expected beats, a monitor pops them.
module tb_axis_pattern_gen;

    localparam int DW = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic [DW-1:0] solid_value = '0;
    logic [CW-1:0] frame_width = '0;
    logic [CW-1:0] frame_height = '0;
    logic [15:0]   gap_cycles = '0;
    logic [15:0]   frames_to_send = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          busy;
    logic          frame_done;
    logic          cfg_error;

    axis_pattern_gen #(
        .DATA_WIDTH(DW), .MAX_WIDTH(1920), .MAX_HEIGHT(1080), .CHECK_SHIFT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .solid_value(solid_value), .frame_width(frame_width), .frame_height(frame_height),
        .gap_cycles(gap_cycles), .frames_to_send(frames_to_send),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    acc_cnt = 0;
    int    done_cnt = 0;
    int    idle_cnt = 0;
    int    gap_seen = -1;
    bit    rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l, input logic u);
        beat_t b;
        b.d = d; b.l = l; b.u = u;
        exp_q.push_back(b);
    endtask

    // 4x2 h-ramp frame, hand-tabulated: base, base+1, base+2, base+3 on both lines.
    task automatic push_4x2_hramp(input logic [DW-1:0] base);
        push(base,         1'b0, 1'b1);
        push(base + 8'd1,  1'b0, 1'b0);
        push(base + 8'd2,  1'b0, 1'b0);
        push(base + 8'd3,  1'b1, 1'b0);
        push(base,         1'b0, 1'b0);
        push(base + 8'd1,  1'b0, 1'b0);
        push(base + 8'd2,  1'b0, 1'b0);
        push(base + 8'd3,  1'b1, 1'b0);
    endtask

    task automatic set_cfg(input logic [1:0] p, input logic [DW-1:0] sv, input int w, input int h,
                           input int gap, input int fts);
        pattern_sel    = p;
        solid_value    = sv;
        frame_width    = CW'(w);
        frame_height   = CW'(h);
        gap_cycles     = 16'(gap);
        frames_to_send = 16'(fts);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_beats(input int n, input string name);
        int base = acc_cnt;
        int t = 0;
        while ((acc_cnt - base) < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk({name, "_timeout"}, 32'(acc_cnt - base), 32'(n));
    endtask

    // Counts frame_done pulses; drops enable on the n-th so the generator stays in IDLE.
    task automatic wait_frames(input int n, input string name);
        int k = 0;
        int t = 0;
        while (k < n && t < 5000) begin
            @(negedge clk);
            t++;
            if (frame_done) k++;
        end
        enable = 1'b0;
        if (t >= 5000) chk({name, "_timeout"}, 32'(k), 32'(n));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: any presented beat (stalled or accepted) must equal the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            idle_cnt = 0;
        end else if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q[0];
                chk(m_axis_tready ? "beat" : "stall",
                    {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, {22'd0, e.d, e.l, e.u});
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    if (e.u) gap_seen = idle_cnt;
                    idle_cnt = 0;
                end
            end
        end else begin
            idle_cnt++;
        end
        if (rst_n && frame_done) done_cnt++;
    end

    initial begin
        int d0;
        int a0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {21'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                              busy, frame_done, cfg_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 4x2 h-ramp frame
        set_cfg(2'd1, 8'h00, 4, 2, 0, 1);
        push_4x2_hramp(8'd0);
        d0 = done_cnt;
        enable = 1'b1;
        @(negedge clk);
        chk("t1_busy_run", 32'(busy), 32'd1);
        wait_frames(1, "t1");
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_frame_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_idle", {30'd0, m_axis_tvalid, busy}, 32'd0);

        // Two frames with a 3-cycle gap; frame_idx advances the ramp
        do_reset();
        set_cfg(2'd1, 8'h00, 4, 2, 3, 2);
        push_4x2_hramp(8'd0);
        push_4x2_hramp(8'd1);
        d0 = done_cnt;
        gap_seen = -1;
        enable = 1'b1;
        wait_frames(2, "t2");
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_gap_cycles", 32'(gap_seen), 32'd3);
        chk("t2_frame_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("t2_idle", {30'd0, m_axis_tvalid, busy}, 32'd0);

        // 16x4 checkerboard under random backpressure
        do_reset();
        set_cfg(2'd3, 8'hFF, 16, 4, 0, 1);
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 16; xx++)
                push((xx >= 8) ? 8'hFF : 8'h00, xx == 15, (xx == 0) && (yy == 0));
        a0 = acc_cnt;
        rand_rdy = 1'b1;
        enable = 1'b1;
        wait_frames(1, "t3");
        rand_rdy = 1'b0;
        chk("t3_beats", 32'(acc_cnt - a0), 32'd64);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Continuous mode, enable dropped mid-frame: frame still completes
        do_reset();
        set_cfg(2'd1, 8'h00, 4, 2, 0, 0);
        push_4x2_hramp(8'd0);
        a0 = acc_cnt;
        enable = 1'b1;
        wait_beats(3, "t4");
        enable = 1'b0;
        wait_frames(1, "t4");
        chk("t4_beats", 32'(acc_cnt - a0), 32'd8);
        chk("t4_idle", {30'd0, m_axis_tvalid, busy}, 32'd0);

        // Illegal widths: 0 and MAX_WIDTH+1
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_cfg(2'd1, 8'h00, (k == 0) ? 0 : 1921, 2, 0, 1);
            a0 = acc_cnt;
            enable = 1'b1;
            repeat (3) @(negedge clk);
            chk("t5_cfg_error_set", 32'(cfg_error), 32'd1);
            chk("t5_no_valid", {30'd0, m_axis_tvalid, busy}, 32'd0);
            enable = 1'b0;
            @(negedge clk);
            chk("t5_cfg_error_clr", 32'(cfg_error), 32'd0);
            chk("t5_no_beats", 32'(acc_cnt - a0), 32'd0);
        end

        // Width=height=1: a single beat carrying both tuser and tlast
        set_cfg(2'd0, 8'h5A, 1, 1, 0, 1);
        push(8'h5A, 1'b1, 1'b1);
        enable = 1'b1;
        wait_frames(1, "t5b");
        chk("t5b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset at beat 5, restart from (0,0) with frame_idx=0
        do_reset();
        set_cfg(2'd1, 8'h00, 4, 2, 0, 0);
        push_4x2_hramp(8'd0);
        enable = 1'b1;
        wait_beats(4, "t6a");
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid_in_reset", {30'd0, m_axis_tvalid, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_4x2_hramp(8'd0);
        a0 = acc_cnt;
        rst_n = 1'b1;
        wait_beats(2, "t6b");
        enable = 1'b0;
        wait_frames(1, "t6");
        chk("t6_beats", 32'(acc_cnt - a0), 32'd8);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
